// File: rtl/alu_sequencer.sv
// Packet-driven sequencer: parses UART byte packets, echoes payloads or drives
// an external ALU over a stream of 32-bit operands, and returns the accumulator.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_start_o,
    input  logic        alu_done_i,
    input  logic [31:0] alu_result_i,
    output logic        error_o
);
    localparam logic [2:0] HDR   = 3'd0;
    localparam logic [2:0] ECHO  = 3'd1;
    localparam logic [2:0] OPND  = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] SEND  = 3'd5;
    localparam logic [2:0] DRAIN = 3'd6;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAC;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    logic [2:0]  state;
    logic [1:0]  hcnt;
    logic [15:0] rem;
    logic [1:0]  bidx;
    logic [7:0]  opcode;
    logic [7:0]  len_lo;
    logic        first_div;
    logic [31:0] acc;
    logic [31:0] opnd;

    logic        rx_fire;
    logic        tx_fire;
    logic [15:0] length;
    logic [1:0]  code;
    logic [31:0] word;

    always_comb begin
        rx_ready_o = 1'b0;
        if (!rst) begin
            case (state)
                HDR, OPND, DRAIN: rx_ready_o = 1'b1;
                ECHO:             rx_ready_o = !tx_valid_o;
                default:          rx_ready_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        rx_fire = rx_valid_i & rx_ready_o;
        tx_fire = tx_valid_o & tx_ready_i;
        length  = {rx_data_i, len_lo};
        // first operand byte lands in bits 7:0 after four shifts
        word    = {rx_data_i, opnd[31:8]};
        case (opcode)
            OP_ADD:  code = 2'b01;
            OP_MUL:  code = 2'b10;
            OP_DIV:  code = 2'b11;
            default: code = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HDR;
            hcnt        <= '0;
            rem         <= '0;
            bidx        <= '0;
            opcode      <= '0;
            len_lo      <= '0;
            first_div   <= 1'b0;
            acc         <= '0;
            opnd        <= '0;
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            alu_op_o    <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_start_o <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            alu_start_o <= 1'b0;
            error_o     <= 1'b0;
            case (state)
                HDR: if (rx_fire) begin
                    hcnt <= hcnt + 2'd1;
                    case (hcnt)
                        2'd0: opcode <= rx_data_i;
                        2'd2: len_lo <= rx_data_i;
                        2'd3: begin
                            rem       <= length - 16'd4;
                            bidx      <= '0;
                            first_div <= (code == 2'b11);
                            acc       <= (code == 2'b10) ? 32'd1 : 32'd0;
                            if (length < 16'd4) begin
                                error_o <= 1'b1;
                            end else if ((code == 2'b00 && opcode != OP_ECHO) ||
                                         (code != 2'b00 && length[1:0] != 2'b00)) begin
                                error_o <= 1'b1;
                                if (length != 16'd4) state <= DRAIN;
                            end else if (code == 2'b00) begin
                                if (length != 16'd4) state <= ECHO;
                            end else begin
                                state <= (length == 16'd4) ? SEND : OPND;
                            end
                        end
                        default: ;
                    endcase
                end
                ECHO: begin
                    if (rx_fire) begin
                        tx_data_o  <= rx_data_i;
                        tx_valid_o <= 1'b1;
                        rem        <= rem - 16'd1;
                    end else if (tx_fire) begin
                        tx_valid_o <= 1'b0;
                        if (rem == 16'd0) state <= HDR;
                    end
                end
                OPND: if (rx_fire) begin
                    opnd <= word;
                    rem  <= rem - 16'd1;
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        if (first_div) begin
                            acc       <= word;
                            first_div <= 1'b0;
                            if (rem == 16'd1) state <= SEND;
                        end else begin
                            alu_start_o <= 1'b1;
                            alu_a_o     <= acc;
                            alu_b_o     <= word;
                            alu_op_o    <= code;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: state <= WAIT;
                WAIT: if (alu_done_i) begin
                    acc      <= alu_result_i;
                    alu_op_o <= 2'b00;
                    state    <= (rem == 16'd0) ? SEND : OPND;
                end
                SEND: begin
                    if (!tx_valid_o) begin
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= acc[{bidx, 3'b000} +: 8];
                    end else if (tx_fire) begin
                        tx_valid_o <= 1'b0;
                        bidx       <= bidx + 2'd1;
                        if (bidx == 2'd3) state <= HDR;
                    end
                end
                DRAIN: if (rx_fire) begin
                    rem <= rem - 16'd1;
                    if (rem == 16'd1) state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a packet-level reference model queues the
// expected tx bytes and ALU launches; a monitor pops and compares them.
module tb_alu_sequencer;
    logic        clk;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_start_o;
    logic        alu_done_i;
    logic [31:0] alu_result_i;
    logic        error_o;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_exp_t;

    logic [7:0] exp_tx[$];
    alu_exp_t   exp_alu[$];
    int checks = 0;
    int fails = 0;
    int exp_err = 0;
    int err_seen = 0;
    int ready_mode = 0;
    bit alu_hold = 0;
    bit force_done = 0;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_start_o(alu_start_o), .alu_done_i(alu_done_i),
        .alu_result_i(alu_result_i), .error_o(error_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // External ALU: divide by zero yields all ones, passed through untouched.
    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            2'b01:   return a + b;
            2'b10:   return a * b;
            2'b11:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model(input logic [7:0] p[$]);
        logic [15:0] l16;
        int          len;
        logic [1:0]  code;
        logic [31:0] acc;
        logic [31:0] v;
        alu_exp_t    e;
        l16 = {p[3], p[2]};
        len = int'(l16);
        if (len < 4) begin
            exp_err++;
            return;
        end
        case (p[0])
            8'hAD:   code = 2'b01;
            8'hAC:   code = 2'b10;
            8'hD1:   code = 2'b11;
            default: code = 2'b00;
        endcase
        if ((code == 2'b00 && p[0] != 8'hEC) || (code != 2'b00 && (len - 4) % 4 != 0)) begin
            exp_err++;
            return;
        end
        if (code == 2'b00) begin
            for (int i = 4; i < len; i++) exp_tx.push_back(p[i]);
            return;
        end
        acc = (code == 2'b10) ? 32'd1 : 32'd0;
        for (int k = 0; k < (len - 4) / 4; k++) begin
            v = {p[7 + 4 * k], p[6 + 4 * k], p[5 + 4 * k], p[4 + 4 * k]};
            if (code == 2'b11 && k == 0) begin
                acc = v;
            end else begin
                e.op = code;
                e.a  = acc;
                e.b  = v;
                exp_alu.push_back(e);
                acc = alu_ref(code, acc, v);
            end
        end
        for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8 * i +: 8]);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (rx_ready_o) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL rx_accept_timeout: byte %h not accepted, required acceptance within 3000 cycles", b);
        end
    endtask

    task automatic send_pkt(input logic [7:0] p[$]);
        model(p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_alu.size() == 0 && !tx_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout: tx queue %0d alu queue %0d pending, required 0", exp_tx.size(), exp_alu.size());
        end
    endtask

    task automatic rand_pkt();
        logic [7:0]  p[$];
        logic [7:0]  opc;
        logic [15:0] len;
        logic [31:0] v;
        int          kind;
        int          n;
        kind = $urandom_range(0, 6);
        p = {};
        n = 0;
        case (kind)
            0: begin opc = 8'hEC; n = $urandom_range(0, 6); end
            1, 2, 3: begin
                opc = (kind == 1) ? 8'hAD : (kind == 2) ? 8'hAC : 8'hD1;
                n = 4 * $urandom_range(0, 3);
            end
            4: begin
                opc = 8'hAD;
                if ($urandom_range(0, 1) == 1) opc = 8'hD1;
                n = 4 * $urandom_range(0, 1) + $urandom_range(1, 3);
            end
            5: begin
                opc = 8'($urandom);
                if (opc == 8'hEC || opc == 8'hAD || opc == 8'hAC || opc == 8'hD1) opc = 8'h55;
                n = $urandom_range(0, 3);
            end
            default: begin opc = 8'($urandom); n = -1; end
        endcase
        len = (n < 0) ? 16'($urandom_range(0, 3)) : 16'(n + 4);
        p = {opc, 8'($urandom), len[7:0], len[15:8]};
        for (int i = 0; i < n; i += 4) begin
            v = $urandom;
            if (kind == 3 && $urandom_range(0, 2) == 0) v = 32'($urandom_range(0, 5));
            if (kind == 2) v = 32'($urandom_range(0, 300));
            for (int j = 0; j < 4 && i + j < n; j++) p.push_back(v[8 * j +: 8]);
        end
        send_pkt(p);
    endtask

    // tx_ready pattern: random with 75% duty, or strict toggle
    initial begin
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) tx_ready_i = !tx_ready_i;
            else tx_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // ALU stand-in: captures a launch, answers 1..3 cycles later
    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          busy;
        int          lat;
        busy = 0;
        lat = 0;
        rop = '0;
        ra = '0;
        rb = '0;
        alu_done_i = 1'b0;
        alu_result_i = '0;
        forever begin
            @(posedge clk);
            #1;
            alu_done_i = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (force_done) begin
                alu_done_i   = 1'b1;
                alu_result_i = 32'hDEAD_BEEF;
            end else if (busy) begin
                if (!alu_hold) begin
                    if (lat <= 1) begin
                        alu_done_i   = 1'b1;
                        alu_result_i = alu_ref(rop, ra, rb);
                        busy = 0;
                    end else begin
                        lat--;
                    end
                end
            end else if (alu_start_o) begin
                rop  = alu_op_o;
                ra   = alu_a_o;
                rb   = alu_b_o;
                busy = 1;
                lat  = $urandom_range(1, 3);
            end
        end
    end

    initial begin
        logic [7:0] eb;
        alu_exp_t   ea;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_valid_o) begin
                    checks++;
                    if (rx_ready_o) begin
                        fails++;
                        $display("FAIL rx_ready_during_tx_valid: got %b required 0", rx_ready_o);
                    end
                end
                if (tx_valid_o && tx_ready_i) begin
                    checks++;
                    if (exp_tx.size() == 0) begin
                        fails++;
                        $display("FAIL tx_unexpected: got %h required no byte", tx_data_o);
                    end else begin
                        eb = exp_tx.pop_front();
                        if (tx_data_o !== eb) begin
                            fails++;
                            $display("FAIL tx_byte: got %h required %h", tx_data_o, eb);
                        end
                    end
                end
                if (alu_start_o) begin
                    checks++;
                    if (exp_alu.size() == 0) begin
                        fails++;
                        $display("FAIL alu_unexpected: got op %b a %h b %h required no launch", alu_op_o, alu_a_o, alu_b_o);
                    end else begin
                        ea = exp_alu.pop_front();
                        if (alu_op_o !== ea.op || alu_a_o !== ea.a || alu_b_o !== ea.b) begin
                            fails++;
                            $display("FAIL alu_launch: got op %b a %h b %h required op %b a %h b %h",
                                     alu_op_o, alu_a_o, alu_b_o, ea.op, ea.a, ea.b);
                        end
                    end
                end
                if (error_o) err_seen++;
            end
        end
    end

    initial begin
        logic [7:0] p[$];
        alu_exp_t   e;
        bit         ok;
        rst = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_rx_ready", 32'(rx_ready_o), 32'd0);
        chk("reset_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("reset_tx_data", 32'(tx_data_o), 32'd0);
        chk("reset_alu_op", 32'(alu_op_o), 32'd0);
        chk("reset_alu_a", alu_a_o, 32'd0);
        chk("reset_alu_b", alu_b_o, 32'd0);
        chk("reset_alu_start", 32'(alu_start_o), 32'd0);
        chk("reset_error", 32'(error_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("hdr_rx_ready", 32'(rx_ready_o), 32'd1);

        p = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        p = {8'hAC, 8'h00, 8'h04, 8'h00};
        send_pkt(p);
        p = {8'hD1, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_idle();
        ready_mode = 1;
        p = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_pkt(p);
        wait_idle();
        ready_mode = 0;
        p = {8'hAD, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(p);
        p = {8'hAD, 8'h00, 8'h04, 8'h00};
        send_pkt(p);
        wait_idle();
        chk("malformed_error_count", 32'(err_seen), 32'(exp_err));

        // Reset while the ALU operation is outstanding, then a stray done.
        @(negedge clk);
        alu_hold = 1;
        e.op = 2'b01;
        e.a  = 32'd0;
        e.b  = 32'h1234_5678;
        exp_alu.push_back(e);
        p = {8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (p[i]) send_byte(p[i]);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_alu.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("wait_launch_seen", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        force_done = 1;
        @(negedge clk);
        force_done = 0;
        alu_hold = 0;
        repeat (10) @(negedge clk);
        chk("post_reset_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("post_reset_rx_ready", 32'(rx_ready_o), 32'd1);
        p = {8'hAC, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_idle();

        for (int n = 0; n < 40; n++) rand_pkt();
        wait_idle();
        chk("final_error_count", 32'(err_seen), 32'(exp_err));
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("alu_queue_empty", 32'(exp_alu.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL use a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_data_i  input  8  byte from UART receiver.
REQ-005 rx_valid_i  input  1  rx_data_i valid.
REQ-006 rx_ready_o  output  1  sequencer accepts byte; transfer = rx_valid_i & rx_ready_o.
REQ-007 tx_data_o  output  8  byte to UART transmitter.
REQ-008 tx_valid_o  output  1  tx_data_o valid.
REQ-009 tx_ready_i  input  1  transmitter accepts byte; transfer = tx_valid_o & tx_ready_i.
REQ-010 alu_op_o  output  2  ALU op: 01 add, 10 mul, 11 div; 00 idle.
REQ-011 alu_a_o  output  32  accumulator operand.
REQ-012 alu_b_o  output  32  new operand.
REQ-013 alu_start_o  output  1  one-cycle pulse launching an ALU operation.
REQ-014 alu_done_i  input  1  ALU result valid, one-cycle pulse.
REQ-015 alu_result_i  input  32  ALU result, valid when alu_done_i is high.
REQ-016 error_o  output  1  one-cycle pulse on a malformed packet.

Function
REQ-017 Packet format SHALL be: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB, then payload. Length counts all bytes including the 4 header bytes.
REQ-018 Opcodes SHALL be 0xEC echo, 0xAD add, 0xAC mul, 0xD1 div. Any other opcode is invalid.
REQ-019 States SHALL be HDR, ECHO, OPND, EXEC, WAIT, SEND, DRAIN. HDR is entered at reset.
REQ-020 HDR: rx_ready_o=1; count 4 bytes. After byte3:
- length<4 -> error_o pulse, HDR.
- invalid opcode, or arithmetic opcode with (length-4) mod 4 != 0 -> error_o pulse, DRAIN (or HDR if length==4).
- echo -> ECHO (or HDR if length==4).
- arithmetic -> OPND (or SEND if length==4).
REQ-021 ECHO: rx_ready_o = !tx_valid_o. Each accepted byte SHALL be registered into tx_data_o, with tx_valid_o=1 the next cycle and held until tx_ready_i. After length-4 bytes are forwarded and the last byte is transmitted, go to HDR.
REQ-022 Accumulator init SHALL be 0 for add and 1 for mul. For div, the first operand loads the accumulator directly, with no ALU operation.
REQ-023 OPND: rx_ready_o=1; assemble a 32-bit operand little-endian (first byte = bits 7:0). On the 4th byte go to EXEC, except for the first div operand, which loads the accumulator and stays in OPND (or goes to SEND if it was the last operand).
REQ-024 EXEC (one cycle): alu_start_o=1, alu_a_o=accumulator, alu_b_o=operand, alu_op_o per opcode; then WAIT. alu_start_o SHALL rise exactly one cycle after the operand's 4th byte is accepted.
REQ-025 WAIT: rx_ready_o=0; alu_a_o, alu_b_o and alu_op_o held stable. On alu_done_i, accumulator <= alu_result_i, then go to OPND, or to SEND if all operands are consumed.
REQ-026 alu_done_i SHALL be ignored outside WAIT. Divide-by-zero results SHALL be passed through unchecked.
REQ-027 SEND: emit the 4 accumulator bytes little-endian, each held until tx_ready_i; after the 4th transfer go to HDR. rx_ready_o=0.
REQ-028 DRAIN: rx_ready_o=1; discard length-4 bytes; then go to HDR. No tx output.
REQ-029 The byte counter SHALL be 16 bits; length 0xFFFF SHALL be handled without wrap error.
REQ-030 Byte order on tx SHALL be exactly payload order (echo) or LSB first (result). No bytes are dropped or duplicated under any tx_ready_i pattern.

Reset
REQ-031 rst SHALL force: state=HDR, counters=0, accumulator=0, tx_valid_o=0, alu_start_o=0, alu_op_o=00, error_o=0, rx_ready_o=0 during reset; alu_a_o, alu_b_o, tx_data_o=0.
REQ-032 rst mid-packet or mid-ALU-operation SHALL abandon the packet. A following alu_done_i SHALL be ignored. The next accepted byte is treated as byte0.

Verification
REQ-033 Add: AD 00 0C 00 + operands 5, 7 (LE) -> two alu_start pulses (a=0,b=5; a=5,b=7), tx bytes 0C 00 00 00.
REQ-034 Mul zero operands: AC 00 04 00 -> no alu_start, tx 01 00 00 00.
REQ-035 Div: D1 00 0C 00 + 100, 7 -> one alu_start with op=11, a=100, b=7; with ALU returning 14 -> tx 0E 00 00 00.
REQ-036 Echo with backpressure: EC 00 07 00 41 42 43, tx_ready_i toggling every cycle -> tx 41 42 43 exactly once each, in order; rx_ready_o low while tx_valid_o is high.
REQ-037 Malformed: AD 00 06 00 AA BB, then AD 00 04 00 -> one error_o pulse, AA/BB drained, then tx 00 00 00 00.
REQ-038 Reset in WAIT, then alu_done_i pulse -> no tx output, state HDR, next packet processed normally.
